dma_controller: RTL and testbench

Memory-to-memory copy engine that moves 16-bit words from the external ROM/flash port into the CPU's memory map (program RAM, sprite/tile/palette VRAM, sound registers). Sits directly downstream of the memory controller's DMA register decode, which supplies `dma_en` and `dma_mode`. While busy, it owns the memory bus and stalls the CPU. A top-level mux routes `bus_*` into the memory controller in place of the CPU signals whenever `busy` is high.

---
 rtl/dma_controller.sv | 155 +++++++++++++++
 tb/tb_dma_controller.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_controller.sv
// dma_controller: ROM-to-memory-map word copy engine.
// The CPU programs SRC/DST/AMT through the DMA register window; a nonzero AMT
// write starts a copy that alternates ROM reads (REQ) and bus writes (WRITE).
// While busy the engine owns the memory bus; the CPU is stalled and its
// register writes are dropped.
// SRC is assembled from two DATA_W halves, so SRC_W must equal 2*DATA_W and
// ADDR_W must equal DATA_W.
module dma_controller #(
    parameter int SRC_W  = 32,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dma_en,
    input  logic [1:0]        dma_mode,
    input  logic              memwrite,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [SRC_W-1:0]  rom_addr,
    output logic              rom_req,
    input  logic              rom_ack,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_write,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_SRC_L = 2'd0;
    localparam logic [1:0] MODE_SRC_U = 2'd1;
    localparam logic [1:0] MODE_DST   = 2'd2;
    localparam logic [1:0] MODE_AMT   = 2'd3;

    state_t            state_q, state_d;
    logic [SRC_W-1:0]  src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

    // CPU register writes are only honoured while the engine is idle.
    logic cpu_wr;
    assign cpu_wr = dma_en & memwrite & (state_q == S_IDLE);

    // Next-state, register updates and FSM outputs.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        rem_d       = rem_q;
        data_d      = data_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rom_req     = 1'b0;
        bus_write   = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_wr) begin
                    case (dma_mode)
                        MODE_SRC_L: src_d = {src_q[SRC_W-1:DATA_W], writedata};
                        MODE_SRC_U: src_d = {writedata, src_q[DATA_W-1:0]};
                        MODE_DST:   dst_d = writedata;
                        MODE_AMT: begin
                            rem_d = writedata;
                            // A zero count is stored but never starts a copy.
                            if (writedata != '0)
                                state_d = S_REQ;
                        end
                        default: ;
                    endcase
                end
            end
            S_REQ: begin
                rom_req = 1'b1;
                busy    = 1'b1;
                // Wait as long as the ROM needs; there is no timeout.
                if (rom_ack) begin
                    data_d  = rom_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                bus_write   = 1'b1;
                busy        = 1'b1;
                // Remember what was driven so bus_addr/bus_wdata hold after WRITE.
                bus_addr_d  = dst_q;
                bus_wdata_d = data_q;
                src_d       = src_q + SRC_W'(1);
                dst_d       = dst_q + ADDR_W'(1);
                rem_d       = rem_q - DATA_W'(1);
                state_d     = (rem_q == DATA_W'(1)) ? S_DONE : S_REQ;
            end
            S_DONE: begin
                // busy is already low here so the CPU resumes one cycle early.
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs: live during WRITE, otherwise hold the last written values.
    always_comb begin
        rom_addr  = src_q;
        bus_addr  = (state_q == S_WRITE) ? dst_q  : bus_addr_q;
        bus_wdata = (state_q == S_WRITE) ? data_q : bus_wdata_q;
    end

    // Register readback; the AMT slot returns the live remaining count.
    always_comb begin
        dma_rdata = '0;
        case (dma_mode)
            MODE_SRC_L: dma_rdata = src_q[DATA_W-1:0];
            MODE_SRC_U: dma_rdata = src_q[SRC_W-1:DATA_W];
            MODE_DST:   dma_rdata = dst_q;
            MODE_AMT:   dma_rdata = rem_q;
            default:    dma_rdata = '0;
        endcase
    end

    // State and datapath registers; synchronous active-low reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            data_q      <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            rem_q       <= rem_d;
            data_q      <= data_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

endmodule

// File: tb/tb_dma_controller.sv
// Directed self-checking bench for dma_controller.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dma_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_en;
    logic [1:0]  dma_mode;
    logic        memwrite;
    logic [15:0] writedata;
    logic [15:0] dma_rdata;
    logic [31:0] rom_addr;
    logic        rom_req;
    logic        rom_ack = 1'b0;
    logic [15:0] rom_data = 16'h0;
    logic [15:0] bus_addr;
    logic        bus_write;
    logic [15:0] bus_wdata;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    dma_controller #(.SRC_W(32), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .dma_en(dma_en), .dma_mode(dma_mode), .memwrite(memwrite),
        .writedata(writedata), .dma_rdata(dma_rdata),
        .rom_addr(rom_addr), .rom_req(rom_req), .rom_ack(rom_ack), .rom_data(rom_data),
        .bus_addr(bus_addr), .bus_write(bus_write), .bus_wdata(bus_wdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // ROM model: word i (relative to rom_base) returns rom_base_data + i,
    // acked in the first REQ cycle unless i == stall_idx, which waits stall_cyc cycles.
    logic [31:0] rom_base      = 32'h0;
    logic [15:0] rom_base_data = 16'h0;
    logic [31:0] stall_idx     = 32'hFFFF_FFFF;
    int          stall_cyc     = 0;
    logic        force_ack     = 1'b0;
    logic [31:0] rom_idx;
    int          wait_cnt = 0;
    int          lat;

    always @(negedge clk) begin
        if (force_ack) begin
            rom_ack  = 1'b1;
            rom_data = 16'hDEAD;
        end else if (rom_req === 1'b1) begin
            rom_idx = rom_addr - rom_base;
            lat     = (rom_idx == stall_idx) ? stall_cyc : 0;
            if (wait_cnt >= lat) begin
                rom_ack  = 1'b1;
                rom_data = rom_base_data + rom_idx[15:0];
                wait_cnt = 0;
            end else begin
                rom_ack  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            rom_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    // Event counters for bus writes and done pulses.
    int wr_cnt   = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (bus_write === 1'b1) wr_cnt = wr_cnt + 1;
        if (done === 1'b1)      done_cnt = done_cnt + 1;
    end

    task automatic cpu_write(input logic [1:0] m, input logic [15:0] d);
        @(negedge clk);
        dma_en = 1'b1; memwrite = 1'b1; dma_mode = m; writedata = d;
        @(negedge clk);
        dma_en = 1'b0; memwrite = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] m, output logic [15:0] v);
        dma_mode = m;
        #1;
        v = dma_rdata;
    endtask

    task automatic setup(input logic [31:0] s, input logic [15:0] d);
        cpu_write(2'd0, s[15:0]);
        cpu_write(2'd1, s[31:16]);
        cpu_write(2'd2, d);
    endtask

    task automatic test_reset;
        logic [15:0] v;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, rom_req, bus_write, done} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0000", {busy, rom_req, bus_write, done});
        end
        checks++;
        if (rom_addr !== 32'h0 || bus_addr !== 16'h0 || bus_wdata !== 16'h0) begin
            errors++; $display("FAIL reset_bus got %h/%h/%h exp 0/0/0", rom_addr, bus_addr, bus_wdata);
        end
        for (int m = 0; m < 4; m++) begin
            read_reg(m[1:0], v);
            checks++;
            if (v !== 16'h0) begin
                errors++; $display("FAIL reset_reg%0d got %h exp 0000", m, v);
            end
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic eb, er, ew, ed;
        logic [15:0] v;
        int w;
        rom_base = 32'h100; rom_base_data = 16'h00A1; stall_idx = 32'hFFFF_FFFF;
        setup(32'h0000_0100, 16'h2000);
        cpu_write(2'd3, 16'd3);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            eb = (k <= 6); er = (k == 1 || k == 3 || k == 5);
            ew = (k == 2 || k == 4 || k == 6); ed = (k == 7);
            checks++;
            if ({busy, rom_req, bus_write, done} !== {eb, er, ew, ed}) begin
                errors++; $display("FAIL basic_ctrl_c%0d got %b exp %b", k, {busy, rom_req, bus_write, done}, {eb, er, ew, ed});
            end
            if (er) begin
                checks++;
                if (rom_addr !== 32'h100 + 32'((k - 1) / 2)) begin
                    errors++; $display("FAIL basic_romaddr_c%0d got %h exp %h", k, rom_addr, 32'h100 + 32'((k - 1) / 2));
                end
            end
            if (ew) begin
                w = k / 2 - 1;
                checks++;
                if (bus_addr !== 16'h2000 + 16'(w) || bus_wdata !== 16'h00A1 + 16'(w)) begin
                    errors++; $display("FAIL basic_wr_c%0d got %h:%h exp %h:%h", k, bus_addr, bus_wdata, 16'h2000 + 16'(w), 16'h00A1 + 16'(w));
                end
            end
            if (k == 3) begin
                checks++;
                if (bus_addr !== 16'h2000 || bus_wdata !== 16'h00A1) begin
                    errors++; $display("FAIL basic_hold got %h:%h exp 2000:00a1", bus_addr, bus_wdata);
                end
            end
        end
        read_reg(2'd0, v); checks++;
        if (v !== 16'h0103) begin errors++; $display("FAIL basic_srcl got %h exp 0103", v); end
        read_reg(2'd1, v); checks++;
        if (v !== 16'h0000) begin errors++; $display("FAIL basic_srcu got %h exp 0000", v); end
        read_reg(2'd2, v); checks++;
        if (v !== 16'h2003) begin errors++; $display("FAIL basic_dst got %h exp 2003", v); end
        read_reg(2'd3, v); checks++;
        if (v !== 16'h0000) begin errors++; $display("FAIL basic_amt got %h exp 0000", v); end
    endtask

    task automatic test_amt_zero;
        int bad = 0;
        int d0;
        logic [15:0] v;
        d0 = done_cnt;
        cpu_write(2'd3, 16'd0);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            if (busy !== 1'b0 || rom_req !== 1'b0 || done !== 1'b0 || bus_write !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL amt0_activity got %0d active cycles exp 0", bad); end
        checks++;
        if (done_cnt != d0) begin errors++; $display("FAIL amt0_done got %0d pulses exp 0", done_cnt - d0); end
        read_reg(2'd3, v); checks++;
        if (v !== 16'h0) begin errors++; $display("FAIL amt0_amt got %h exp 0000", v); end
    endtask

    task automatic test_rom_stall;
        logic eb, er, ew, ed;
        int bad_req = 0;
        int w0;
        w0 = wr_cnt;
        rom_base = 32'h300; rom_base_data = 16'h00C0; stall_idx = 32'd1; stall_cyc = 5;
        setup(32'h0000_0300, 16'h3000);
        w0 = wr_cnt;
        cpu_write(2'd3, 16'd2);
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(negedge clk);
            eb = (k <= 9); er = (k == 1) || (k >= 3 && k <= 8);
            ew = (k == 2 || k == 9); ed = (k == 10);
            checks++;
            if ({busy, rom_req, bus_write, done} !== {eb, er, ew, ed}) begin
                errors++; $display("FAIL stall_ctrl_c%0d got %b exp %b", k, {busy, rom_req, bus_write, done}, {eb, er, ew, ed});
            end
            if (k >= 3 && k <= 8 && rom_addr !== 32'h301) bad_req++;
            if (k == 9) begin
                checks++;
                if (bus_addr !== 16'h3001 || bus_wdata !== 16'h00C1) begin
                    errors++; $display("FAIL stall_wr2 got %h:%h exp 3001:00c1", bus_addr, bus_wdata);
                end
            end
        end
        checks++;
        if (bad_req != 0) begin errors++; $display("FAIL stall_romaddr got %0d unstable cycles exp 0", bad_req); end
        checks++;
        if (wr_cnt - w0 != 2) begin errors++; $display("FAIL stall_wrcount got %0d exp 2", wr_cnt - w0); end
        stall_idx = 32'hFFFF_FFFF; stall_cyc = 0;
    endtask

    task automatic test_busy_writes;
        logic eb, ew, ed;
        logic [15:0] v;
        int w;
        rom_base = 32'h400; rom_base_data = 16'h00D0;
        setup(32'h0000_0400, 16'h5000);
        cpu_write(2'd3, 16'd3);
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            eb = (k <= 6); ew = (k == 2 || k == 4 || k == 6); ed = (k == 7);
            checks++;
            if ({busy, bus_write, done} !== {eb, ew, ed}) begin
                errors++; $display("FAIL busywr_ctrl_c%0d got %b exp %b", k, {busy, bus_write, done}, {eb, ew, ed});
            end
            if (ew) begin
                w = k / 2 - 1;
                checks++;
                if (bus_addr !== 16'h5000 + 16'(w) || bus_wdata !== 16'h00D0 + 16'(w)) begin
                    errors++; $display("FAIL busywr_wr_c%0d got %h:%h exp %h:%h", k, bus_addr, bus_wdata, 16'h5000 + 16'(w), 16'h00D0 + 16'(w));
                end
            end
            if (k == 2) begin
                dma_en = 1'b1; memwrite = 1'b1; dma_mode = 2'd2; writedata = 16'h4400;
            end else if (k == 3) begin
                dma_mode = 2'd3; writedata = 16'd9;
            end else if (k == 4) begin
                dma_en = 1'b0; memwrite = 1'b0;
            end
        end
        read_reg(2'd2, v); checks++;
        if (v !== 16'h5003) begin errors++; $display("FAIL busywr_dst got %h exp 5003", v); end
        read_reg(2'd3, v); checks++;
        if (v !== 16'h0000) begin errors++; $display("FAIL busywr_amt got %h exp 0000", v); end
    endtask

    task automatic test_wrap;
        logic [15:0] v;
        rom_base = 32'h0000_FFFF; rom_base_data = 16'h00B0;
        setup(32'h0000_FFFF, 16'hFFFF);
        cpu_write(2'd3, 16'd2);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 1 || k == 3) begin
                checks++;
                if (rom_req !== 1'b1 || rom_addr !== ((k == 1) ? 32'h0000_FFFF : 32'h0001_0000)) begin
                    errors++; $display("FAIL wrap_rom_c%0d got %b:%h exp 1:%h", k, rom_req, rom_addr, (k == 1) ? 32'h0000_FFFF : 32'h0001_0000);
                end
            end
            if (k == 2 || k == 4) begin
                checks++;
                if (bus_write !== 1'b1 || bus_addr !== ((k == 2) ? 16'hFFFF : 16'h0000) ||
                    bus_wdata !== ((k == 2) ? 16'h00B0 : 16'h00B1)) begin
                    errors++; $display("FAIL wrap_wr_c%0d got %b:%h:%h", k, bus_write, bus_addr, bus_wdata);
                end
            end
            if (k == 5) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b0) begin
                    errors++; $display("FAIL wrap_done got %b%b exp 10", done, busy);
                end
            end
        end
        read_reg(2'd0, v); checks++;
        if (v !== 16'h0001) begin errors++; $display("FAIL wrap_srcl got %h exp 0001", v); end
        read_reg(2'd1, v); checks++;
        if (v !== 16'h0001) begin errors++; $display("FAIL wrap_srcu got %h exp 0001", v); end
        read_reg(2'd2, v); checks++;
        if (v !== 16'h0001) begin errors++; $display("FAIL wrap_dst got %h exp 0001", v); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] v;
        int bad = 0;
        int w0, d0;
        rom_base = 32'h600; rom_base_data = 16'h00E0;
        setup(32'h0000_0600, 16'h6000);
        cpu_write(2'd3, 16'd4);
        @(negedge clk);
        checks++;
        if (bus_write !== 1'b1) begin errors++; $display("FAIL rstmid_inwrite got %b exp 1", bus_write); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, rom_req, bus_write, done} !== 4'b0000) begin
            errors++; $display("FAIL rstmid_ctrl got %b exp 0000", {busy, rom_req, bus_write, done});
        end
        checks++;
        if (rom_addr !== 32'h0 || bus_addr !== 16'h0 || bus_wdata !== 16'h0) begin
            errors++; $display("FAIL rstmid_bus got %h/%h/%h exp 0/0/0", rom_addr, bus_addr, bus_wdata);
        end
        for (int m = 0; m < 4; m++) begin
            read_reg(m[1:0], v);
            checks++;
            if (v !== 16'h0) begin errors++; $display("FAIL rstmid_reg%0d got %h exp 0000", m, v); end
        end
        rst = 1'b1;
        w0 = wr_cnt; d0 = done_cnt;
        force_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || rom_req !== 1'b0 || bus_write !== 1'b0 || done !== 1'b0) bad++;
        end
        force_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rstmid_lateack got %0d active cycles exp 0", bad); end
        checks++;
        if (wr_cnt != w0 || done_cnt != d0) begin
            errors++; $display("FAIL rstmid_events got wr %0d done %0d exp 0 0", wr_cnt - w0, done_cnt - d0);
        end
    endtask

    initial begin
        rst = 1'b0; dma_en = 1'b0; dma_mode = 2'd0; memwrite = 1'b0; writedata = 16'h0;
        test_reset();
        test_basic();
        test_amt_zero();
        test_rom_stall();
        test_busy_writes();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
